// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and the sync/blank bundle
// for the 640x480@60 scanout of a 160x120 framebuffer.
package vga_pkg;

  localparam int unsigned HCNT_W   = 10;
  localparam int unsigned VCNT_W   = 10;
  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_X_W   = $clog2(FB_W);
  localparam int unsigned FB_Y_W   = $clog2(FB_H);
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [HCNT_W-1:0] H_VIS  = 10'd640;
  localparam logic [HCNT_W-1:0] H_FP   = 10'd16;
  localparam logic [HCNT_W-1:0] H_SYNC = 10'd96;
  localparam logic [HCNT_W-1:0] H_BP   = 10'd48;

  localparam logic [VCNT_W-1:0] V_VIS  = 10'd480;
  localparam logic [VCNT_W-1:0] V_FP   = 10'd10;
  localparam logic [VCNT_W-1:0] V_SYNC = 10'd2;
  localparam logic [VCNT_W-1:0] V_BP   = 10'd33;

  localparam logic [HCNT_W-1:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [HCNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [HCNT_W-1:0] H_LAST       = H_SYNC_END + H_BP - 10'd1;
  localparam logic [VCNT_W-1:0] V_SYNC_START = V_VIS + V_FP;
  localparam logic [VCNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [VCNT_W-1:0] V_LAST       = V_SYNC_END + V_BP - 10'd1;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

  // y*160 + x built from shifts: 160 = 128 + 32.
  function automatic logic [ADDR_W-1:0] fb_index(input logic [FB_Y_W-1:0] y,
                                                 input logic [FB_X_W-1:0] x);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with combinational sync, visible-region,
// frame-start and vblank decode from the current count.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  output logic [FB_X_W-1:0] fb_x_o,
  output logic [FB_Y_W-1:0] fb_y_o,
  output sync_t             sync_o,
  output logic              frame_start_o,
  output logic              in_vblank_o
);

  logic [HCNT_W-1:0] h_q, h_d;
  logic [VCNT_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + HCNT_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    sync_o.hs_n = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    sync_o.vs_n = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    sync_o.vis  = (h_q < H_VIS) && (v_q < V_VIS);
  end

  // Gated by resetn so both flags read 0 while reset is held at (0,0).
  assign frame_start_o = resetn && (h_q == '0) && (v_q == '0);
  assign in_vblank_o   = resetn && (v_q >= V_VIS);

  // 4x replication: each framebuffer pixel covers 4 columns and 4 lines.
  assign fb_x_o = h_q[FB_X_W+1:2];
  assign fb_y_o = v_q[FB_Y_W+1:2];

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: address generation, 2-stage pin pipeline matching the
// 1-clk framebuffer read latency, and 1-bit to 8-bit colour expansion.
module vga_scanout
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic                fb_rd_en,
  input  logic [COLOUR_W-1:0] fb_data,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic                vga_sync_n,
  output logic                frame_start,
  output logic                in_vblank
);

  logic [FB_X_W-1:0] fb_x;
  logic [FB_Y_W-1:0] fb_y;
  sync_t             sync_now;
  sync_t             sync1_q, sync2_q;
  logic [23:0]       rgb_d, rgb_q;

  vga_timing_gen u_timing (
    .clk           (clk),
    .resetn        (resetn),
    .fb_x_o        (fb_x),
    .fb_y_o        (fb_y),
    .sync_o        (sync_now),
    .frame_start_o (frame_start),
    .in_vblank_o   (in_vblank)
  );

  assign fb_rd_en = sync_now.vis;
  assign fb_addr  = sync_now.vis ? fb_index(fb_y, fb_x) : '0;

  // fb_data lines up with sync1_q; a blanked stage never lets fb_data through.
  always_comb begin
    rgb_d = '0;
    if (sync1_q.vis) begin
      rgb_d = {{8{fb_data[2]}}, {8{fb_data[1]}}, {8{fb_data[0]}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= SYNC_IDLE;
      sync2_q <= SYNC_IDLE;
      rgb_q   <= '0;
    end else begin
      sync1_q <= sync_now;
      sync2_q <= sync1_q;
      rgb_q   <= rgb_d;
    end
  end

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = sync2_q.hs_n;
  assign vga_vs      = sync2_q.vs_n;
  assign vga_blank_n = sync2_q.vis;
  assign vga_sync_n  = 1'b0;

endmodule
